// File: rtl/sd_crc_lanes.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc_lanes
// Description : Multi-lane serial CRC engine for SD CMD/DAT lines. One LFSR
//               per lane, optional check phase that compares received CRC
//               bits against the computed remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc_lanes #(
   parameter int unsigned         CrcWidth = 16,
   parameter logic [CrcWidth-1:0] Poly     = 16'h1021,
   parameter int unsigned         NumLanes = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clk_en_i,
   input  logic                         start_i,
   input  logic [NumLanes-1:0]          lanes_active_i,
   input  logic                         check_i,
   input  logic                         end_data_i,
   input  logic [NumLanes-1:0]          dat_i,
   output logic [NumLanes*CrcWidth-1:0] crc_o,
   output logic                         busy_o,
   output logic                         valid_o,
   output logic [NumLanes-1:0]          crc_ok_o,
   output logic                         crc_err_o
);

   localparam int unsigned    CntW    = $clog2(CrcWidth);
   localparam logic [CntW-1:0] CntLast = CntW'(CrcWidth - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCalc  = 2'd1,
      StCheck = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [NumLanes*CrcWidth-1:0] crc_q, crc_d;
   logic [NumLanes-1:0]          mask_q, mask_d;
   logic                         chk_q, chk_d;
   logic                         valid_q, valid_d;
   logic [NumLanes-1:0]          ok_q, ok_d;
   logic [CntW-1:0]              cnt_q, cnt_d;

   // Per-lane datapath: next LFSR value and check-phase mismatch flag
   logic [NumLanes*CrcWidth-1:0] step_crc;
   logic [NumLanes-1:0]          miss;

   generate
      for (genvar l = 0; l < NumLanes; l++) begin : g_lane
         logic [CrcWidth-1:0] cur;
         logic                fb;
         logic                exp_bit;

         assign cur     = crc_q[l*CrcWidth +: CrcWidth];
         assign fb      = dat_i[l] ^ cur[CrcWidth-1];
         // Inactive lanes are cleared at start and simply keep their zero
         assign step_crc[l*CrcWidth +: CrcWidth] =
            mask_q[l] ? ({cur[CrcWidth-2:0], 1'b0} ^ (fb ? Poly : '0)) : cur;
         // CRC bits are received MSB first, one per check cycle
         assign exp_bit = cur[CntLast - cnt_q];
         assign miss[l] = mask_q[l] & (dat_i[l] ^ exp_bit);
      end
   endgenerate

   // Next-state logic: start has priority over everything in any state
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      mask_d  = mask_q;
      chk_d   = chk_q;
      valid_d = valid_q;
      ok_d    = ok_q;
      cnt_d   = cnt_q;

      if (start_i) begin
         state_d = StCalc;
         crc_d   = '0;
         mask_d  = lanes_active_i;
         chk_d   = check_i;
         valid_d = 1'b0;
         ok_d    = '1;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StCalc: begin
               crc_d = step_crc;
               if (end_data_i) begin
                  cnt_d = '0;
                  if (chk_q) begin
                     state_d = StCheck;
                  end else begin
                     state_d = StIdle;
                     valid_d = 1'b1;
                  end
               end
            end
            StCheck: begin
               ok_d  = ok_q & ~miss;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = StIdle;
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State registers; only bit-clock-enabled edges advance anything
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         crc_q   <= '0;
         mask_q  <= '0;
         chk_q   <= 1'b0;
         valid_q <= 1'b0;
         ok_q    <= '1;
         cnt_q   <= '0;
      end else if (clk_en_i) begin
         state_q <= state_d;
         crc_q   <= crc_d;
         mask_q  <= mask_d;
         chk_q   <= chk_d;
         valid_q <= valid_d;
         ok_q    <= ok_d;
         cnt_q   <= cnt_d;
      end
   end

   assign crc_o     = crc_q;
   assign busy_o    = (state_q != StIdle);
   assign valid_o   = valid_q;
   assign crc_ok_o  = ok_q;
   assign crc_err_o = valid_q & (|(mask_q & ~ok_q));

endmodule
`default_nettype wire

// File: tb/tb_sd_crc_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_crc_lanes
// Description : Self-checking bench for sd_crc_lanes (CRC16 x4 and CRC7 x1),
//               reference CRC by polynomial long division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_crc_lanes;

   logic clk;
   logic rst_n;

   // CRC16, 4-lane instance
   logic        en16, start16, chk16, end16;
   logic [3:0]  mask16, dat16;
   logic [63:0] crc16;
   logic        busy16, valid16, err16;
   logic [3:0]  ok16;

   // CRC7, 1-lane instance
   logic        en7, start7, chk7, end7;
   logic [0:0]  mask7, dat7;
   logic [6:0]  crc7;
   logic        busy7, valid7, err7;
   logic [0:0]  ok7;

   int n_tests;
   int n_fail;

   sd_crc_lanes #(.CrcWidth(16), .Poly(16'h1021), .NumLanes(4)) u_dut16 (
      .clk_i(clk), .rst_ni(rst_n), .clk_en_i(en16), .start_i(start16),
      .lanes_active_i(mask16), .check_i(chk16), .end_data_i(end16),
      .dat_i(dat16), .crc_o(crc16), .busy_o(busy16), .valid_o(valid16),
      .crc_ok_o(ok16), .crc_err_o(err16)
   );

   sd_crc_lanes #(.CrcWidth(7), .Poly(7'h09), .NumLanes(1)) u_dut7 (
      .clk_i(clk), .rst_ni(rst_n), .clk_en_i(en7), .start_i(start7),
      .lanes_active_i(mask7), .check_i(chk7), .end_data_i(end7),
      .dat_i(dat7), .crc_o(crc7), .busy_o(busy7), .valid_o(valid7),
      .crc_ok_o(ok7), .crc_err_o(err7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic check_val(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: remainder of M(x)*x^w divided by the generator polynomial
   function automatic logic [15:0] crc_div(input int w, input logic [15:0] poly, input bit msg[$]);
      bit work[$];
      bit gen[$];
      logic [15:0] r;
      work = msg;
      for (int k = 0; k < w; k++) work.push_back(1'b0);
      gen.push_back(1'b1);
      for (int j = w - 1; j >= 0; j--) gen.push_back(poly[j]);
      for (int i = 0; i < msg.size(); i++)
         if (work[i])
            for (int j = 0; j <= w; j++) work[i+j] = work[i+j] ^ gen[j];
      r = '0;
      for (int k = 0; k < w; k++) r = {r[14:0], work[msg.size()+k]};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One enabled CRC16 cycle, optionally preceded by two disabled edges that must change nothing
   task automatic gtick16(input bit gate);
      logic [79:0] snap;
      if (gate) begin
         snap = {6'd0, crc16, busy16, valid16, ok16, err16};
         en16 = 1'b0;
         tick();
         tick();
         check_val("hold16", {6'd0, crc16, busy16, valid16, ok16, err16}, snap);
         en16 = 1'b1;
      end
      tick();
   endtask

   task automatic gtick7(input bit gate);
      logic [79:0] snap;
      if (gate) begin
         snap = {69'd0, crc7, busy7, valid7, ok7, err7};
         en7 = 1'b0;
         tick();
         tick();
         check_val("hold7", {69'd0, crc7, busy7, valid7, ok7, err7}, snap);
         en7 = 1'b1;
      end
      tick();
   endtask

   task automatic run16(input logic [3:0] mask, input bit do_chk, input int nbits, input bit ones,
                        input int bad_lane, input int bad_bit, input bit gate, input string tag);
      bit          q[4][$];
      logic [15:0] ec[4];
      logic [63:0] ecat;
      logic [3:0]  eok;
      int          bcnt;
      bit          flip;
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < nbits; i++) q[l].push_back(ones ? 1'b1 : 1'($urandom));
      ecat = '0;
      eok  = '1;
      for (int l = 0; l < 4; l++) begin
         ec[l] = mask[l] ? crc_div(16, 16'h1021, q[l]) : 16'h0;
         ecat[l*16 +: 16] = ec[l];
         if (mask[l] && do_chk && l == bad_lane) eok[l] = 1'b0;
      end
      en16    = 1'b1;
      start16 = 1'b1;
      mask16  = mask;
      chk16   = do_chk;
      end16   = 1'b0;
      dat16   = 4'($urandom);
      gtick16(gate);
      start16 = 1'b0;
      bcnt    = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int l = 0; l < 4; l++) dat16[l] = q[l][i];
         end16 = (i == nbits - 1);
         if (busy16) bcnt++;
         gtick16(gate);
      end
      end16 = 1'b0;
      check_val({tag, "_crc_calc"}, {16'd0, crc16}, {16'd0, ecat});
      if (do_chk) begin
         check_val({tag, "_novalid_calc"}, {79'd0, valid16}, 80'd0);
         for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 4; l++) begin
               flip = (l == bad_lane) && ((15 - k) == bad_bit);
               dat16[l] = mask[l] ? (ec[l][15-k] ^ flip) : 1'($urandom);
            end
            if (busy16) bcnt++;
            gtick16(gate);
         end
      end
      check_val({tag, "_valid"}, {79'd0, valid16}, 80'd1);
      check_val({tag, "_ok"}, {76'd0, ok16}, {76'd0, eok});
      check_val({tag, "_err"}, {79'd0, err16}, {79'd0, |(mask & ~eok)});
      check_val({tag, "_crc_final"}, {16'd0, crc16}, {16'd0, ecat});
      check_val({tag, "_busy_len"}, 80'(bcnt), 80'(nbits + (do_chk ? 16 : 0)));
      check_val({tag, "_idle"}, {79'd0, busy16}, 80'd0);
      // Result must persist across idle cycles
      dat16 = 4'($urandom);
      end16 = 1'b1;
      tick();
      end16 = 1'b0;
      check_val({tag, "_valid_held"}, {15'd0, valid16, crc16}, {15'd0, 1'b1, ecat});
   endtask

   task automatic run7(input logic [39:0] msg, input bit gate, input bit start_end,
                       input logic [6:0] expv, input string tag);
      en7    = 1'b1;
      start7 = 1'b1;
      end7   = start_end;
      chk7   = 1'b0;
      mask7  = 1'b1;
      dat7   = 1'($urandom);
      gtick7(gate);
      start7 = 1'b0;
      end7   = 1'b0;
      check_val({tag, "_started"}, {78'd0, busy7, valid7}, 80'b10);
      for (int i = 0; i < 40; i++) begin
         dat7 = msg[39-i];
         end7 = (i == 39);
         gtick7(gate);
      end
      end7 = 1'b0;
      check_val({tag, "_crc"}, {73'd0, crc7}, {73'd0, expv});
      check_val({tag, "_flags"}, {76'd0, valid7, busy7, ok7, err7}, 80'b1010);
   endtask

   initial begin
      logic [3:0] rmask;
      bit         rchk;
      int         rlane;
      n_tests = 0;
      n_fail  = 0;
      en16 = 1'b0; start16 = 1'b0; chk16 = 1'b0; end16 = 1'b0; mask16 = '0; dat16 = '0;
      en7  = 1'b0; start7  = 1'b0; chk7  = 1'b0; end7  = 1'b0; mask7  = '0; dat7  = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      check_val("rst16", {6'd0, crc16, busy16, valid16, ok16, err16}, {6'd0, 64'd0, 1'b0, 1'b0, 4'hF, 1'b0});
      check_val("rst7", {69'd0, crc7, busy7, valid7, ok7, err7}, {69'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // CRC7 command vectors
      run7(40'h40_0000_0000, 1'b0, 1'b0, 7'h4A, "crc7_cmd0");
      run7(40'h51_0000_0000, 1'b0, 1'b0, 7'h2A, "crc7_cmd17");
      run7(40'h40_0000_0000, 1'b1, 1'b0, 7'h4A, "crc7_gated");

      // Abort after 20 data bits; the restarting start also carries end_data
      en7 = 1'b1; start7 = 1'b1; mask7 = 1'b1; chk7 = 1'b0;
      tick();
      start7 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         dat7 = 1'($urandom);
         tick();
      end
      run7(40'h40_0000_0000, 1'b0, 1'b1, 7'h4A, "crc7_abort");
      en7 = 1'b0;

      // CRC16 4-lane directed blocks
      run16(4'hF, 1'b1, 1024, 1'b1, -1, 0, 1'b0, "ones_ok");
      run16(4'hF, 1'b1, 1024, 1'b1, 2, 5, 1'b0, "ones_bad2");
      run16(4'b0001, 1'b1, 64, 1'b0, -1, 0, 1'b0, "mask1");
      run16(4'b0000, 1'b1, 10, 1'b0, -1, 0, 1'b0, "mask0");

      // Randomised blocks
      for (int t = 0; t < 12; t++) begin
         rmask = 4'($urandom);
         rchk  = 1'($urandom);
         rlane = (rchk && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
         run16(rmask, rchk, int'($urandom_range(1, 40)), 1'b0, rlane,
               int'($urandom_range(0, 15)), 1'($urandom), "rand");
      end

      // Asynchronous reset in the middle of the check phase
      en16 = 1'b1; start16 = 1'b1; mask16 = 4'hF; chk16 = 1'b1; end16 = 1'b0;
      tick();
      start16 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dat16 = 4'($urandom);
         end16 = (i == 7);
         tick();
      end
      end16 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         dat16 = 4'($urandom);
         tick();
      end
      check_val("midchk_busy", {78'd0, busy16, valid16}, 80'b10);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst", {6'd0, crc16, busy16, valid16, ok16, err16}, {6'd0, 64'd0, 1'b0, 1'b0, 4'hF, 1'b0});
      #1 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check_val("post_rst", {78'd0, busy16, valid16}, 80'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
